// File: rtl/sbox_sweep_checker.sv
// Exhaustive S-box self-check: sweeps every input, tracks seen outputs in a
// bitmap and reports bijectivity, duplicate/fixed-point counts and first duplicate.
module sbox_sweep_checker #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    output logic [WIDTH-1:0] a_out,
    input  logic [WIDTH-1:0] z_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   dup_count,
    output logic [WIDTH:0]   fixed_count,
    output logic             first_dup_valid,
    output logic [WIDTH-1:0] first_dup_addr
);

    localparam int               DEPTH = 1 << WIDTH;
    localparam logic [WIDTH-1:0] LAST  = '1;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t             state;
    logic [DEPTH-1:0]   seen;
    logic               hit;
    logic               is_fixed;
    logic [WIDTH:0]     dup_next;

    // Saturating increment; counts cannot reach all-ones here, but never wrap.
    function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH:0] v);
        return (v == '1) ? v : v + (WIDTH+1)'(1);
    endfunction

    always_comb begin
        hit      = seen[z_in];
        is_fixed = (z_in == a_out);
        dup_next = hit ? sat_inc(dup_count) : dup_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            seen            <= '0;
            a_out           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            dup_count       <= '0;
            fixed_count     <= '0;
            first_dup_valid <= 1'b0;
            first_dup_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    a_out <= '0;
                    if (start) begin
                        seen            <= '0;
                        dup_count       <= '0;
                        fixed_count     <= '0;
                        first_dup_valid <= 1'b0;
                        first_dup_addr  <= '0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        state           <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (en) begin
                        if (hit) begin
                            dup_count <= dup_next;
                            if (!first_dup_valid) begin
                                first_dup_valid <= 1'b1;
                                first_dup_addr  <= a_out;
                            end
                        end else begin
                            seen[z_in] <= 1'b1;
                        end
                        if (is_fixed)
                            fixed_count <= sat_inc(fixed_count);
                        // Terminal check precedes the increment so a_out never wraps.
                        if (a_out == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (dup_next == '0);
                        end else begin
                            a_out <= a_out + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    a_out <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_sweep_checker.sv
// Randomized bench for sbox_sweep_checker against a table-driven reference model.
module tb_sbox_sweep_checker;

    localparam int W = 9;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst, start, en;
    logic [W-1:0] a_out, z_in;
    logic         busy, done, pass;
    logic [W:0]   dup_count, fixed_count;
    logic         first_dup_valid;
    logic [W-1:0] first_dup_addr;

    logic [W-1:0] sbox_tab [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign z_in = sbox_tab[a_out];

    sbox_sweep_checker #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en),
        .a_out(a_out), .z_in(z_in), .busy(busy), .done(done), .pass(pass),
        .dup_count(dup_count), .fixed_count(fixed_count),
        .first_dup_valid(first_dup_valid), .first_dup_addr(first_dup_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 0 identity, 1 constant 0, 2 xor 1, 3 affine bijection, 4 and 1FE,
    // 5 random permutation, 6 random table
    task automatic fill(input int mode);
        int j;
        logic [W-1:0] t;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: sbox_tab[i] = W'(i);
                1: sbox_tab[i] = '0;
                2: sbox_tab[i] = W'(i) ^ 9'h001;
                3: sbox_tab[i] = W'(i * 5 + 3);
                4: sbox_tab[i] = W'(i) & 9'h1FE;
                5: sbox_tab[i] = W'(i);
                default: sbox_tab[i] = W'($urandom_range(0, N - 1));
            endcase
        end
        if (mode == 5) begin
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = sbox_tab[i];
                sbox_tab[i] = sbox_tab[j];
                sbox_tab[j] = t;
            end
        end
    endtask

    task automatic model(output int e_dup, output int e_fix, output int e_fv, output int e_fa);
        bit seen [N];
        int z;
        e_dup = 0; e_fix = 0; e_fv = 0; e_fa = 0;
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        for (int a = 0; a < N; a++) begin
            z = int'(sbox_tab[a]);
            if (seen[z]) begin
                e_dup++;
                if (e_fv == 0) begin
                    e_fv = 1;
                    e_fa = a;
                end
            end else begin
                seen[z] = 1'b1;
            end
            if (z == a) e_fix++;
        end
    endtask

    task automatic run_sweep(input string name, input int low_pct, input bit extra_start);
        int e_dup, e_fix, e_fv, e_fa;
        int cycles, stalls, ndone;
        bit got;
        model(e_dup, e_fix, e_fv, e_fa);
        @(negedge clk);
        start = 1'b1;
        en    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({name, " busy_rise"}, 32'(busy), 1);
        chk({name, " a_out_first"}, 32'(a_out), 0);
        cycles = 0; stalls = 0; got = 1'b0;
        while (!got && cycles < 5000) begin
            @(negedge clk);
            en    = ($urandom_range(0, 99) < low_pct) ? 1'b0 : 1'b1;
            start = (extra_start && (cycles == 100 || cycles == 300)) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            cycles++;
            if (!en) stalls++;
            if (done) got = 1'b1;
        end
        en = 1'b1;
        start = 1'b0;
        chk({name, " done_seen"}, 32'(got), 1);
        if (!got) return;
        chk({name, " latency"}, cycles + 1, N + 1 + stalls);
        chk({name, " pass"}, 32'(pass), (e_dup == 0) ? 1 : 0);
        chk({name, " dup_count"}, 32'(dup_count), e_dup);
        chk({name, " fixed_count"}, 32'(fixed_count), e_fix);
        chk({name, " first_dup_valid"}, 32'(first_dup_valid), e_fv);
        chk({name, " first_dup_addr"}, 32'(first_dup_addr), e_fa);
        @(posedge clk);
        #1;
        chk({name, " done_fall"}, 32'(done), 0);
        chk({name, " busy_fall"}, 32'(busy), 0);
        chk({name, " a_out_idle"}, 32'(a_out), 0);
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (done || busy) ndone++;
        end
        chk({name, " no_extra_sweep"}, ndone, 0);
        chk({name, " pass_hold"}, 32'(pass), (e_dup == 0) ? 1 : 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " a_out"}, 32'(a_out), 0);
        chk({name, " busy"}, 32'(busy), 0);
        chk({name, " done"}, 32'(done), 0);
        chk({name, " pass"}, 32'(pass), 0);
        chk({name, " dup_count"}, 32'(dup_count), 0);
        chk({name, " fixed_count"}, 32'(fixed_count), 0);
        chk({name, " first_dup_valid"}, 32'(first_dup_valid), 0);
        chk({name, " first_dup_addr"}, 32'(first_dup_addr), 0);
    endtask

    initial begin
        int cycles, ndone;
        rst = 1'b1; start = 1'b0; en = 1'b1;
        fill(0);
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        fill(0); run_sweep("identity", 0, 1'b0);
        fill(1); run_sweep("constant", 0, 1'b0);
        fill(2); run_sweep("xor1", 0, 1'b0);
        fill(3); run_sweep("sbox9_stall", 25, 1'b0);
        run_sweep("sbox9_full", 0, 1'b0);
        fill(4); run_sweep("and1fe_restart", 0, 1'b1);
        fill(5); run_sweep("rand_perm", 25, 1'b0);
        fill(6); run_sweep("rand_table", 10, 1'b0);

        // Mid-sweep reset at a_out = 200
        fill(0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        while (a_out != W'(200) && cycles < 1000) begin
            @(posedge clk);
            #1 cycles++;
        end
        chk("midrst reach_200", 32'(a_out), 200);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 chk_all_zero("midrst");
        @(negedge clk) rst = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (done) ndone++;
        end
        chk("midrst no_done", ndone, 0);
        run_sweep("after_rst", 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
